// File: rtl/rs_pkg.sv
// Shared RS decoder definitions: field parameters, solver state encoding and a
// reference GF(2^M) multiply for models.
package rs_pkg;

  localparam int             RS_M         = 8;
  localparam int             RS_T         = 8;
  localparam logic [RS_M:0]  RS_PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {IDLE, ITER, DONE} bm_state_e;

  function automatic logic [RS_M-1:0] gf_mul(input logic [RS_M-1:0] a,
                                             input logic [RS_M-1:0] b);
    logic [RS_M-1:0] acc;
    logic [RS_M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < RS_M; i++) begin
      if (b[i]) acc ^= sh;
      sh = sh[RS_M-1] ? ({sh[RS_M-2:0], 1'b0} ^ RS_PRIM_POLY[RS_M-1:0])
                      : {sh[RS_M-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_ribm_solver_if.sv
// Syndrome stream from the syndrome stage into the key-equation solver.
interface rs_ribm_solver_if #(parameter int M = 8);
  logic         synd_valid;
  logic         synd_start;
  logic [M-1:0] synd_in;
  logic         synd_ready;

  modport master (output synd_valid, output synd_start, output synd_in, input  synd_ready);
  modport slave  (input  synd_valid, input  synd_start, input  synd_in, output synd_ready);
endinterface

// File: rtl/gf_mul_param.sv
// Combinational GF(2^M) multiplier, shift-and-add with modular reduction.
module gf_mul_param #(
  parameter int         M         = 8,
  parameter logic [M:0] PRIM_POLY = 9'h11D
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ PRIM_POLY[M-1:0]) : {sh[M-2:0], 1'b0};
    end
    p = acc;
  end

endmodule

// File: rtl/rs_ribm_solver.sv
// Inversionless Berlekamp-Massey solver: one iteration per accepted syndrome,
// produces an unnormalised error locator, its degree and a failure flag.
module rs_ribm_solver
  import rs_pkg::*;
#(
  parameter int         M         = RS_M,
  parameter int         T         = RS_T,
  parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  rs_ribm_solver_if.slave      synd,
  output logic [(T+1)*M-1:0]   lambda_out,
  output logic [$clog2(2*T+1)-1:0] lambda_deg,
  output logic                 bm_done,
  output logic                 bm_fail,
  output logic                 busy
);

  localparam int LW = $clog2(2*T+1);
  localparam int RW = $clog2(2*T);

  bm_state_e state, state_nxt;

  logic [T:0][M-1:0]   lam, lam_cur, lam_nxt, lam_q;
  // B_T is always shifted out before it can reach Lambda, so only T coeffs are kept.
  logic [T-1:0][M-1:0] bpol, b_cur, b_nxt;
  logic [T:1][M-1:0]   sbuf;
  logic [T:0][M-1:0]   sb_ext, pd, pg;
  logic [T:1][M-1:0]   pb;
  logic [M-1:0]        gam, gam_cur, gam_nxt, delta;
  logic [LW-1:0]       lreg, l_cur, l_nxt, deg_q;
  logic [RW-1:0]       r, r_cur;
  logic                fail_q, acc, start, step, upd;

  assign acc   = synd.synd_valid & synd.synd_ready;
  assign start = acc & synd.synd_start;
  assign step  = start | (acc & (state == ITER));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (acc && !synd.synd_start && r == RW'(2*T-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign synd.synd_ready = (state != DONE);
  assign busy            = (state == ITER);
  assign bm_done         = (state == DONE);
  assign lambda_out      = lam_q;
  assign lambda_deg      = deg_q;
  assign bm_fail         = fail_q;

  // A start beat runs iteration 0 from the initial polynomials, not the registers.
  always_comb begin
    lam_cur = lam;
    b_cur   = bpol;
    gam_cur = gam;
    l_cur   = lreg;
    r_cur   = r;
    sb_ext  = {sbuf, synd.synd_in};
    if (start) begin
      lam_cur      = '0;
      lam_cur[0]   = M'(1);
      b_cur        = '0;
      b_cur[0]     = M'(1);
      gam_cur      = M'(1);
      l_cur        = '0;
      r_cur        = '0;
      sb_ext[T:1]  = '0;
    end
  end

  for (genvar i = 0; i <= T; i++) begin : g_lane
    gf_mul_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_delta (.a(lam_cur[i]), .b(sb_ext[i]),  .p(pd[i]));
    gf_mul_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_gam   (.a(gam_cur),    .b(lam_cur[i]), .p(pg[i]));
    if (i > 0) begin : g_b
      gf_mul_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_b (.a(delta), .b(b_cur[i-1]), .p(pb[i]));
    end
  end

  always_comb begin
    delta = '0;
    for (int i = 0; i <= T; i++) delta = delta ^ pd[i];
  end

  always_comb begin
    upd        = (delta != '0) && (2 * int'(l_cur) <= int'(r_cur));
    lam_nxt[0] = pg[0];
    for (int i = 1; i <= T; i++) lam_nxt[i] = pg[i] ^ pb[i];
    b_nxt   = upd ? lam_cur[T-1:0] : {b_cur[T-2:0], {M{1'b0}}};
    gam_nxt = upd ? delta : gam_cur;
    l_nxt   = upd ? LW'(int'(r_cur) + 1 - int'(l_cur)) : l_cur;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lam    <= '0;
      bpol   <= '0;
      sbuf   <= '0;
      gam    <= '0;
      lreg   <= '0;
      r      <= '0;
      lam_q  <= '0;
      deg_q  <= '0;
      fail_q <= 1'b0;
    end else if (step) begin
      lam  <= lam_nxt;
      bpol <= b_nxt;
      gam  <= gam_nxt;
      lreg <= l_nxt;
      r    <= r_cur + 1'b1;
      sbuf <= sb_ext[T-1:0];
      if (state_nxt == DONE) begin
        lam_q  <= lam_nxt;
        deg_q  <= l_nxt;
        fail_q <= (l_nxt > LW'(T));
      end
    end
  end

endmodule
